// File: rtl/lc3_seq_ctrl.sv
// lc3_seq_ctrl: Moore fetch/decode/execute sequencer driving LC-3 datapath loads, gates and mux selects.
// Latency: all control outputs are registered and change on the same edge as State_o.
// Backpressure: memory states stall on Mem_Ready_i; after MEM_TIMEOUT idle cycles abort to HALTED with Err_o.
module lc3_seq_ctrl #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Run_i,
   input  logic        Continue_i,
   input  logic [15:0] IR_i,
   input  logic        N_i,
   input  logic        Z_i,
   input  logic        P_i,
   input  logic        Mem_Ready_i,
   output logic        LD_MAR_o,
   output logic        LD_MDR_o,
   output logic        LD_IR_o,
   output logic        LD_PC_o,
   output logic        LD_REG_o,
   output logic        LD_CC_o,
   output logic        LD_BEN_o,
   output logic        GatePC_o,
   output logic        GateMDR_o,
   output logic        GateALU_o,
   output logic        GateMARMUX_o,
   output logic [1:0]  PCMUX_o,
   output logic        ADDR1MUX_o,
   output logic [1:0]  ADDR2MUX_o,
   output logic [1:0]  ALUK_o,
   output logic        DRMUX_o,
   output logic        SR1MUX_o,
   output logic        MIO_EN_o,
   output logic        Mem_CE_o,
   output logic        Mem_WE_o,
   output logic        Err_o,
   output logic [4:0]  State_o
);

   // Counter is wide enough to hold MEM_TIMEOUT-1; the abort fires when it is reached.
   localparam int            CW       = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

   typedef enum logic [4:0] {
      S_HALTED = 5'd0,
      S_F1     = 5'd1,
      S_F2     = 5'd2,
      S_F3     = 5'd3,
      S_DEC    = 5'd4,
      S_EX_ADD = 5'd5,
      S_EX_AND = 5'd6,
      S_EX_NOT = 5'd7,
      S_BR0    = 5'd8,
      S_BR1    = 5'd9,
      S_EX_JMP = 5'd10,
      S_LDR0   = 5'd11,
      S_LDR1   = 5'd12,
      S_LDR2   = 5'd13,
      S_STR0   = 5'd14,
      S_STR1   = 5'd15,
      S_STR2   = 5'd16,
      S_PAUSE  = 5'd17
   } state_t;

   // Full datapath control word; one instance per state.
   typedef struct packed {
      logic       ld_mar;
      logic       ld_mdr;
      logic       ld_ir;
      logic       ld_pc;
      logic       ld_reg;
      logic       ld_cc;
      logic       ld_ben;
      logic       gate_pc;
      logic       gate_mdr;
      logic       gate_alu;
      logic       gate_marmux;
      logic [1:0] pcmux;
      logic       addr1mux;
      logic [1:0] addr2mux;
      logic [1:0] aluk;
      logic       drmux;
      logic       sr1mux;
      logic       mio_en;
      logic       mem_ce;
      logic       mem_we;
   } ctrl_t;

   state_t        state_q, state_d;
   ctrl_t         ctrl_q;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ben_q;
   logic          err_q;
   logic          is_mem;
   logic          tmo;
   state_t        mem_next;
   logic          unused_ir;

   // Only the opcode and the NZP mask are consumed here; operand fields go to the datapath.
   assign unused_ir = ^IR_i[8:0];

   // Moore decode: control word for a given state. HALTED and PAUSE decode to all zeros.
   function automatic ctrl_t decode(input state_t s);
      ctrl_t c;
      c = '0;
      case (s)
         S_F1: begin
            c.gate_pc = 1'b1;
            c.ld_mar  = 1'b1;
            c.pcmux   = 2'b00;
            c.ld_pc   = 1'b1;
         end
         S_F2, S_LDR1: begin
            c.mem_ce = 1'b1;
            c.mio_en = 1'b1;
            c.ld_mdr = 1'b1;
         end
         S_F3: begin
            c.gate_mdr = 1'b1;
            c.ld_ir    = 1'b1;
         end
         S_DEC: c.ld_ben = 1'b1;
         S_EX_ADD, S_EX_AND, S_EX_NOT: begin
            c.gate_alu = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
            c.aluk     = (s == S_EX_ADD) ? 2'b00 : (s == S_EX_AND) ? 2'b01 : 2'b10;
         end
         S_BR1: begin
            c.addr1mux = 1'b0;
            c.addr2mux = 2'b10;
            c.pcmux    = 2'b01;
            c.ld_pc    = 1'b1;
         end
         S_EX_JMP: begin
            c.addr1mux = 1'b1;
            c.addr2mux = 2'b00;
            c.pcmux    = 2'b01;
            c.sr1mux   = 1'b1;
            c.ld_pc    = 1'b1;
         end
         S_LDR0, S_STR0: begin
            c.gate_marmux = 1'b1;
            c.addr1mux    = 1'b1;
            c.addr2mux    = 2'b01;
            c.sr1mux      = 1'b1;
            c.ld_mar      = 1'b1;
         end
         S_LDR2: begin
            c.gate_mdr = 1'b1;
            c.ld_reg   = 1'b1;
            c.ld_cc    = 1'b1;
         end
         S_STR1: begin
            c.gate_alu = 1'b1;
            c.aluk     = 2'b11;
            c.sr1mux   = 1'b0;
            c.mio_en   = 1'b0;
            c.ld_mdr   = 1'b1;
         end
         S_STR2: begin
            c.mem_ce = 1'b1;
            c.mem_we = 1'b1;
         end
         default: c = '0;
      endcase
      return c;
   endfunction

   // Next-state logic, including the shared memory wait/timeout handling.
   always_comb begin
      state_d  = state_q;
      mem_next = state_q;
      is_mem   = 1'b0;
      cnt_d    = '0;
      tmo      = 1'b0;
      case (state_q)
         S_HALTED: if (Run_i) state_d = S_F1;
         S_F1:     state_d = S_F2;
         S_F2: begin
            is_mem   = 1'b1;
            mem_next = S_F3;
         end
         S_F3:     state_d = S_DEC;
         S_DEC: begin
            case (IR_i[15:12])
               4'b0001: state_d = S_EX_ADD;
               4'b0101: state_d = S_EX_AND;
               4'b1001: state_d = S_EX_NOT;
               4'b0000: state_d = S_BR0;
               4'b1100: state_d = S_EX_JMP;
               4'b0110: state_d = S_LDR0;
               4'b0111: state_d = S_STR0;
               4'b1101: state_d = S_PAUSE;
               default: state_d = S_F1;
            endcase
         end
         S_EX_ADD, S_EX_AND, S_EX_NOT: state_d = S_F1;
         S_BR0:    state_d = ben_q ? S_BR1 : S_F1;
         S_BR1, S_EX_JMP, S_LDR2: state_d = S_F1;
         S_LDR0:   state_d = S_LDR1;
         S_LDR1: begin
            is_mem   = 1'b1;
            mem_next = S_LDR2;
         end
         S_STR0:   state_d = S_STR1;
         S_STR1:   state_d = S_STR2;
         S_STR2: begin
            is_mem   = 1'b1;
            mem_next = S_F1;
         end
         S_PAUSE:  if (Continue_i) state_d = S_F1;
         default:  state_d = S_HALTED;
      endcase

      // Ready takes priority over the timeout so a late completion is never discarded.
      if (is_mem) begin
         if (Mem_Ready_i) begin
            state_d = mem_next;
         end else if (cnt_q == CNT_LAST) begin
            state_d = S_HALTED;
            tmo     = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // State, registered control word, branch enable, timeout counter and sticky error.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= S_HALTED;
         ctrl_q  <= '0;
         cnt_q   <= '0;
         ben_q   <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= decode(state_d);
         cnt_q   <= cnt_d;
         if (state_q == S_DEC) ben_q <= (IR_i[11] & N_i) | (IR_i[10] & Z_i) | (IR_i[9] & P_i);
         if (tmo) err_q <= 1'b1;
      end
   end

   assign LD_MAR_o     = ctrl_q.ld_mar;
   assign LD_MDR_o     = ctrl_q.ld_mdr;
   assign LD_IR_o      = ctrl_q.ld_ir;
   assign LD_PC_o      = ctrl_q.ld_pc;
   assign LD_REG_o     = ctrl_q.ld_reg;
   assign LD_CC_o      = ctrl_q.ld_cc;
   assign LD_BEN_o     = ctrl_q.ld_ben;
   assign GatePC_o     = ctrl_q.gate_pc;
   assign GateMDR_o    = ctrl_q.gate_mdr;
   assign GateALU_o    = ctrl_q.gate_alu;
   assign GateMARMUX_o = ctrl_q.gate_marmux;
   assign PCMUX_o      = ctrl_q.pcmux;
   assign ADDR1MUX_o   = ctrl_q.addr1mux;
   assign ADDR2MUX_o   = ctrl_q.addr2mux;
   assign ALUK_o       = ctrl_q.aluk;
   assign DRMUX_o      = ctrl_q.drmux;
   assign SR1MUX_o     = ctrl_q.sr1mux;
   assign MIO_EN_o     = ctrl_q.mio_en;
   assign Mem_CE_o     = ctrl_q.mem_ce;
   assign Mem_WE_o     = ctrl_q.mem_we;
   assign Err_o        = err_q;
   assign State_o      = state_q;

endmodule

// File: tb/tb_lc3_seq_ctrl.sv
// tb_lc3_seq_ctrl: directed bench for the LC-3 sequencer.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: Mem_Ready driven directly to exercise wait, delay and timeout paths.
module tb_lc3_seq_ctrl;

   localparam logic [4:0] HALTED = 5'd0,  F1 = 5'd1,  F2 = 5'd2,  F3 = 5'd3,  DEC = 5'd4;
   localparam logic [4:0] EX_ADD = 5'd5,  EX_JMP = 5'd10, BR0 = 5'd8, BR1 = 5'd9;
   localparam logic [4:0] LDR0 = 5'd11, LDR1 = 5'd12, LDR2 = 5'd13;
   localparam logic [4:0] STR0 = 5'd14, STR1 = 5'd15, STR2 = 5'd16, PAUSE = 5'd17;

   logic        Clk = 1'b0;
   logic        Reset, Run, Continue, N, Z, P, Mem_Ready;
   logic [15:0] IR;
   logic        LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN;
   logic        GatePC, GateMDR, GateALU, GateMARMUX;
   logic [1:0]  PCMUX, ADDR2MUX, ALUK;
   logic        ADDR1MUX, DRMUX, SR1MUX, MIO_EN, Mem_CE, Mem_WE, Err;
   logic [4:0]  State;
   logic [22:0] ctl;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int t0    = 0;
   int stay  = 0;

   lc3_seq_ctrl #(.MEM_TIMEOUT(16)) dut (
      .Clk(Clk), .Reset(Reset), .Run_i(Run), .Continue_i(Continue), .IR_i(IR),
      .N_i(N), .Z_i(Z), .P_i(P), .Mem_Ready_i(Mem_Ready),
      .LD_MAR_o(LD_MAR), .LD_MDR_o(LD_MDR), .LD_IR_o(LD_IR), .LD_PC_o(LD_PC),
      .LD_REG_o(LD_REG), .LD_CC_o(LD_CC), .LD_BEN_o(LD_BEN),
      .GatePC_o(GatePC), .GateMDR_o(GateMDR), .GateALU_o(GateALU), .GateMARMUX_o(GateMARMUX),
      .PCMUX_o(PCMUX), .ADDR1MUX_o(ADDR1MUX), .ADDR2MUX_o(ADDR2MUX), .ALUK_o(ALUK),
      .DRMUX_o(DRMUX), .SR1MUX_o(SR1MUX), .MIO_EN_o(MIO_EN), .Mem_CE_o(Mem_CE),
      .Mem_WE_o(Mem_WE), .Err_o(Err), .State_o(State)
   );

   assign ctl = {LD_MAR, LD_MDR, LD_IR, LD_PC, LD_REG, LD_CC, LD_BEN,
                 GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, ADDR1MUX, ADDR2MUX,
                 ALUK, DRMUX, SR1MUX, MIO_EN, Mem_CE, Mem_WE};

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample just after the edge; bus drivers must never collide.
   task automatic tick();
      @(posedge Clk);
      #1;
      chk("bus_onehot0", 32'($countones({GatePC, GateMDR, GateALU, GateMARMUX}) <= 1), 32'd1);
   endtask

   // From F1 with IR loaded, walk through F2, F3 and into DEC with instant memory.
   task automatic fetch_dec(input logic [15:0] ir);
      IR = ir;
      Mem_Ready = 1'b1;
      tick(); chk("fd_f2", State, F2);
      tick(); chk("fd_f3", State, F3);
      tick(); chk("fd_dec", State, DEC);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      Reset = 1'b1; Run = 1'b0; Continue = 1'b0; IR = 16'h0000;
      N = 1'b0; Z = 1'b0; P = 1'b0; Mem_Ready = 1'b0;
      tick(); tick();
      chk("rst_state", State, HALTED);
      chk("rst_ctl", ctl, 0);
      chk("rst_err", Err, 0);

      // Reset in the middle of a fetch wait
      Reset = 1'b0; Run = 1'b1;
      tick(); chk("f1_state", State, F1);
      chk("f1_ctl", {GatePC, LD_MAR, LD_PC, PCMUX}, 5'b11100);
      Run = 1'b0;
      tick(); chk("f2_state", State, F2);
      chk("f2_ctl", {Mem_CE, MIO_EN, LD_MDR, Mem_WE}, 4'b1110);
      tick(); chk("f2_wait", State, F2);
      Reset = 1'b1;
      tick(); Reset = 1'b0;
      chk("midrst_state", State, HALTED);
      chk("midrst_ctl", ctl, 0);
      chk("midrst_err", Err, 0);

      // ADD with instant memory: 5-cycle instruction
      IR = 16'h1261; Mem_Ready = 1'b1; Run = 1'b1;
      tick(); Run = 1'b0; t0 = cyc;
      chk("add_f1", State, F1);
      tick(); chk("add_f2", State, F2);
      tick(); chk("add_f3", State, F3);
      chk("add_f3_ctl", {GateMDR, LD_IR}, 2'b11);
      tick(); chk("add_dec", State, DEC);
      chk("add_dec_ben", LD_BEN, 1);
      tick(); chk("add_ex", State, EX_ADD);
      chk("add_ex_ctl", {GateALU, ALUK, LD_REG, LD_CC}, 5'b10011);
      tick(); chk("add_next_f1", State, F1);
      chk("add_f1_noreg", {LD_REG, LD_CC}, 2'b00);
      chk("add_period", cyc - t0, 5);

      // BRz taken
      Z = 1'b1; P = 1'b0;
      fetch_dec(16'h0402);
      tick(); chk("brt_br0", State, BR0);
      tick(); chk("brt_br1", State, BR1);
      chk("brt_ctl", {PCMUX, ADDR2MUX, ADDR1MUX, LD_PC}, 6'b011001);
      tick(); chk("brt_f1", State, F1);

      // BRz not taken with only P set
      Z = 1'b0; P = 1'b1;
      fetch_dec(16'h0402);
      chk("brn_dec_ldpc", LD_PC, 0);
      tick(); chk("brn_br0", State, BR0);
      chk("brn_br0_ldpc", LD_PC, 0);
      tick(); chk("brn_f1", State, F1);

      // Branch decision uses BEN captured in DEC, not live Z
      Z = 1'b1; P = 1'b0;
      fetch_dec(16'h0402);
      tick(); Z = 1'b0;
      chk("brr_br0", State, BR0);
      tick(); chk("brr_br1", State, BR1);
      tick(); chk("brr_f1", State, F1);

      // JMP R7
      fetch_dec(16'hC1C0);
      tick(); chk("jmp_state", State, EX_JMP);
      chk("jmp_ctl", {ADDR1MUX, ADDR2MUX, PCMUX, SR1MUX, LD_PC}, 7'b1000111);
      tick(); chk("jmp_f1", State, F1);

      // Unimplemented opcode behaves as NOP
      fetch_dec(16'h3000);
      tick(); chk("nop_f1", State, F1);

      // LDR with Mem_Ready delayed 3 cycles
      fetch_dec(16'h6A41);
      tick(); chk("ldr0_state", State, LDR0);
      chk("ldr0_ctl", {GateMARMUX, ADDR1MUX, ADDR2MUX, SR1MUX, LD_MAR}, 6'b110111);
      Mem_Ready = 1'b0;
      tick(); chk("ldr1_c1", State, LDR1);
      tick(); chk("ldr1_c2", State, LDR1);
      tick(); chk("ldr1_c3", State, LDR1);
      tick(); chk("ldr1_c4", State, LDR1);
      Mem_Ready = 1'b1;
      tick(); chk("ldr2_state", State, LDR2);
      chk("ldr2_ctl", {GateMDR, LD_REG, LD_CC}, 3'b111);
      tick(); chk("ldr_f1", State, F1);
      chk("ldr_f1_cc", LD_CC, 0);
      chk("ldr_err", Err, 0);

      // STR with memory that never answers: timeout abort
      fetch_dec(16'h7E3F);
      tick(); chk("str0_state", State, STR0);
      chk("str0_ctl", {GateMARMUX, LD_MAR}, 2'b11);
      tick(); chk("str1_state", State, STR1);
      chk("str1_ctl", {GateALU, ALUK, SR1MUX, MIO_EN, LD_MDR}, 6'b111001);
      Mem_Ready = 1'b0;
      tick(); chk("str2_state", State, STR2);
      chk("str2_ctl", {Mem_CE, Mem_WE}, 2'b11);
      stay = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (State == STR2) stay++;
      end
      chk("str2_held", stay, 15);
      tick(); chk("tmo_state", State, HALTED);
      chk("tmo_err", Err, 1);
      chk("tmo_ctl", ctl, 0);

      // Err survives a restart and clears only on Reset
      Run = 1'b1; Mem_Ready = 1'b1; IR = 16'h1261;
      tick(); Run = 1'b0;
      chk("restart_f1", State, F1);
      chk("restart_err", Err, 1);
      fetch_dec(16'h1261);
      tick(); chk("restart_ex", State, EX_ADD);
      chk("restart_err2", Err, 1);
      Reset = 1'b1;
      tick(); Reset = 1'b0;
      chk("errclr_state", State, HALTED);
      chk("errclr_err", Err, 0);

      // Mem_Ready on the final allowed cycle beats the timeout
      Run = 1'b1; IR = 16'h7000;
      tick(); Run = 1'b0;
      chk("rw_f1", State, F1);
      fetch_dec(16'h7000);
      tick(); tick();
      chk("rw_str1", State, STR1);
      Mem_Ready = 1'b0;
      tick();
      for (int i = 0; i < 15; i++) tick();
      chk("rw_c16", State, STR2);
      Mem_Ready = 1'b1;
      tick(); chk("rw_f1_after", State, F1);
      chk("rw_err", Err, 0);

      // PAUSE ignores Run and resumes on Continue
      fetch_dec(16'hD000);
      tick(); chk("pause_state", State, PAUSE);
      chk("pause_ctl", ctl, 0);
      Run = 1'b1;
      tick(); chk("pause_run_ign", State, PAUSE);
      Run = 1'b0; Continue = 1'b1;
      tick(); chk("pause_resume", State, F1);
      Continue = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
